// File: rtl/moving_stats_pkg.sv
// Shared types and width helpers for the moving-window statistics engine.
package moving_stats_pkg;

    typedef enum logic [1:0] {
        MODE_AVG  = 2'b00,
        MODE_VAR  = 2'b01,
        MODE_SD   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_VAR,
        ST_ROOT
    } state_e;

    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned depth_log2);
        return data_w + depth_log2;
    endfunction

    function automatic int unsigned sumsq_w(input int unsigned data_w, input int unsigned depth_log2);
        return 2 * data_w + depth_log2;
    endfunction

    // N*sumsq - sum^2 before the final 2*DEPTH_LOG2 shift
    function automatic int unsigned var_w(input int unsigned data_w, input int unsigned depth_log2);
        return 2 * data_w + 2 * depth_log2;
    endfunction

endpackage

// File: rtl/moving_stats_if.sv
// Sample/result handshake bundle between a producer and moving_stats_engine.
interface moving_stats_if #(
    parameter int unsigned DATA_W = 12
);
    logic                  i_SAMPLE_VALID;
    logic                  o_SAMPLE_READY;
    logic [DATA_W-1:0]     i_SAMPLE;
    logic [1:0]            i_MODE;
    logic                  i_FLUSH;
    logic [2*DATA_W-1:0]   o_RESULT;
    logic                  o_RESULT_VALID;
    logic                  o_ERR;
    logic                  o_WINDOW_FULL;

    modport master (
        output i_SAMPLE_VALID, i_SAMPLE, i_MODE, i_FLUSH,
        input  o_SAMPLE_READY, o_RESULT, o_RESULT_VALID, o_ERR, o_WINDOW_FULL
    );

    modport slave (
        input  i_SAMPLE_VALID, i_SAMPLE, i_MODE, i_FLUSH,
        output o_SAMPLE_READY, o_RESULT, o_RESULT_VALID, o_ERR, o_WINDOW_FULL
    );
endinterface

// File: rtl/moving_stats_isqrt.sv
// Restoring bit-serial integer square root, one root bit per cycle.
// The start cycle performs the first iteration, so done pulses DATA_W-1 edges after start.
module moving_stats_isqrt #(
    parameter int unsigned DATA_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*DATA_W-1:0]   radicand,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     root
);
    localparam int unsigned REM_W = DATA_W + 1;
    localparam int unsigned SH_W  = DATA_W + 3;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [REM_W-1:0]    rem_q, rem_d, src_rem;
    logic [DATA_W-1:0]   root_q, root_d, src_root;
    logic [2*DATA_W-1:0] rad_q, rad_d, src_rad;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [SH_W-1:0]     shifted, trial;

    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_root = start ? '0 : root_q;
        src_rad  = start ? radicand : rad_q;
        shifted  = {src_rem, src_rad[2*DATA_W-1 -: 2]};
        trial    = {1'b0, src_root, 2'b01};

        rem_d  = rem_q;
        root_d = root_q;
        rad_d  = rad_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start || busy_q) begin
            if (shifted >= trial) begin
                rem_d  = REM_W'(shifted - trial);
                root_d = {src_root[DATA_W-2:0], 1'b1};
            end else begin
                rem_d  = REM_W'(shifted);
                root_d = {src_root[DATA_W-2:0], 1'b0};
            end
            rad_d  = src_rad << 2;
            cnt_d  = start ? CNT_W'(DATA_W - 1) : cnt_q - 1'b1;
            busy_d = (cnt_d != '0);
            done_d = (cnt_d == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            root_q <= '0;
            rad_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            root_q <= root_d;
            rad_q  <= rad_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign root = root_q;
endmodule

// File: rtl/moving_stats_engine.sv
// Moving-window average / variance / std-dev engine over 2^DEPTH_LOG2 samples.
// Define MOVING_STATS_STDDEV_EN to build the square-root path for mode 10.
module moving_stats_engine
    import moving_stats_pkg::*;
#(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic           i_CLK,
    input  logic           i_RESET,
    moving_stats_if.slave  bus
);
    localparam int unsigned N       = 1 << DEPTH_LOG2;
    localparam int unsigned SUM_W   = sum_w(DATA_W, DEPTH_LOG2);
    localparam int unsigned SUMSQ_W = sumsq_w(DATA_W, DEPTH_LOG2);
    localparam int unsigned VAR_W   = var_w(DATA_W, DEPTH_LOG2);
    localparam int unsigned RES_W   = 2 * DATA_W;
    localparam logic [DEPTH_LOG2:0] FILL_MAX = (DEPTH_LOG2 + 1)'(N);

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [DATA_W-1:0]     win_q [N];
    logic [DATA_W-1:0]     win_d [N];
    logic [DATA_W-1:0]     sample_q, sample_d, oldest_q, oldest_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [SUMSQ_W-1:0]    sumsq_q, sumsq_d, new_sq, old_sq;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [DEPTH_LOG2:0]   fill_q, fill_d;
    logic [RES_W-1:0]      result_q, result_d;
    logic                  valid_q, valid_d, err_q, err_d, full_q, full_d;
    logic [VAR_W-1:0]      var_full;
    logic [RES_W-1:0]      var_val, avg_val;
    logic                  clear;

`ifdef MOVING_STATS_STDDEV_EN
    logic                  sqrt_start, sqrt_busy, sqrt_done;
    logic [DATA_W-1:0]     sqrt_root;

    moving_stats_isqrt #(.DATA_W(DATA_W)) u_isqrt (
        .clk      (i_CLK),
        .rst      (i_RESET),
        .start    (sqrt_start),
        .radicand (var_val),
        .busy     (sqrt_busy),
        .done     (sqrt_done),
        .root     (sqrt_root)
    );
`endif

    always_comb begin
        new_sq   = SUMSQ_W'(sample_q) * SUMSQ_W'(sample_q);
        old_sq   = SUMSQ_W'(oldest_q) * SUMSQ_W'(oldest_q);
        var_full = (VAR_W'(sumsq_q) << DEPTH_LOG2) - VAR_W'(sum_q) * VAR_W'(sum_q);
        var_val  = RES_W'(var_full >> (2 * DEPTH_LOG2));
        avg_val  = RES_W'(sum_q >> DEPTH_LOG2);
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        win_d    = win_q;
        sample_d = sample_q;
        oldest_d = oldest_q;
        sum_d    = sum_q;
        sumsq_d  = sumsq_q;
        ptr_d    = ptr_q;
        fill_d   = fill_q;
        result_d = result_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        full_d   = full_q;
        clear    = 1'b0;
`ifdef MOVING_STATS_STDDEV_EN
        sqrt_start = 1'b0;
`endif

        if (bus.i_FLUSH) begin
            clear   = 1'b1;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_SAMPLE_VALID) begin
                        sample_d = bus.i_SAMPLE;
                        mode_d   = mode_e'(bus.i_MODE);
                        oldest_d = win_q[ptr_q];
                        state_d  = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    sum_d        = sum_q + SUM_W'(sample_q) - SUM_W'(oldest_q);
                    sumsq_d      = sumsq_q + new_sq - old_sq;
                    win_d[ptr_q] = sample_q;
                    ptr_d        = ptr_q + 1'b1;
                    if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
                    full_d       = (fill_d == FILL_MAX);
                    state_d      = ST_VAR;
                end
                ST_VAR: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    case (mode_q)
                        MODE_AVG: result_d = avg_val;
                        MODE_VAR: result_d = var_val;
`ifdef MOVING_STATS_STDDEV_EN
                        MODE_SD: begin
                            sqrt_start = 1'b1;
                            valid_d    = 1'b0;
                            state_d    = ST_ROOT;
                        end
`endif
                        default: begin
                            result_d = '0;
                            err_d    = 1'b1;
                        end
                    endcase
                end
`ifdef MOVING_STATS_STDDEV_EN
                ST_ROOT: begin
                    if (sqrt_done && !sqrt_busy) begin
                        result_d = RES_W'(sqrt_root);
                        valid_d  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        // Flush wipes the window but leaves the last reported result in place
        if (clear) begin
            win_d   = '{default: '0};
            sum_d   = '0;
            sumsq_d = '0;
            ptr_d   = '0;
            fill_d  = '0;
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_AVG;
            win_q    <= '{default: '0};
            sample_q <= '0;
            oldest_q <= '0;
            sum_q    <= '0;
            sumsq_q  <= '0;
            ptr_q    <= '0;
            fill_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            win_q    <= win_d;
            sample_q <= sample_d;
            oldest_q <= oldest_d;
            sum_q    <= sum_d;
            sumsq_q  <= sumsq_d;
            ptr_q    <= ptr_d;
            fill_q   <= fill_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            full_q   <= full_d;
        end
    end

    assign bus.o_SAMPLE_READY = (state_q == ST_IDLE) && !bus.i_FLUSH;
    assign bus.o_RESULT       = result_q;
    assign bus.o_RESULT_VALID = valid_q;
    assign bus.o_ERR          = err_q;
    assign bus.o_WINDOW_FULL  = full_q;
endmodule

// File: tb/tb_moving_stats_engine.sv
// Directed checks of moving_stats_engine at DATA_W=12, DEPTH_LOG2=4.
module tb_moving_stats_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulses = 0;

    moving_stats_if #(.DATA_W(12)) bus ();

    moving_stats_engine #(.DATA_W(12), .DEPTH_LOG2(4)) dut (
        .i_CLK   (clk),
        .i_RESET (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.o_RESULT_VALID) pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [11:0] s, input logic [1:0] m,
                          output logic [23:0] res, output logic err, output int lat,
                          output logic full_upd, output logic rdy_low);
        @(negedge clk);
        bus.i_SAMPLE       = s;
        bus.i_MODE         = m;
        bus.i_SAMPLE_VALID = 1'b1;
        @(posedge clk); #1;
        bus.i_SAMPLE_VALID = 1'b0;
        bus.i_SAMPLE       = '0;
        bus.i_MODE         = '0;
        lat = 0; res = '0; err = 1'b0; full_upd = 1'b0; rdy_low = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) full_upd = bus.o_WINDOW_FULL;
            if (bus.o_RESULT_VALID) begin
                lat = i;
                res = bus.o_RESULT;
                err = bus.o_ERR;
                break;
            end
            rdy_low &= !bus.o_SAMPLE_READY;
        end
        if (lat == 0) chk_eq("op_timeout", 32'(lat), 32'd2);
    endtask

    task automatic do_flush(input logic with_valid);
        @(negedge clk);
        bus.i_FLUSH        = 1'b1;
        bus.i_SAMPLE_VALID = with_valid;
        bus.i_SAMPLE       = 12'd4095;
        #1;
        if (with_valid) chk_eq("ready_during_flush", 32'(bus.o_SAMPLE_READY), 32'd0);
        @(posedge clk); #1;
        bus.i_FLUSH        = 1'b0;
        bus.i_SAMPLE_VALID = 1'b0;
        bus.i_SAMPLE       = '0;
    endtask

    logic [23:0] res;
    logic        err, full_upd, rdy_low;
    int          lat, p0;

    initial begin
        bus.i_SAMPLE_VALID = 1'b0;
        bus.i_SAMPLE       = '0;
        bus.i_MODE         = '0;
        bus.i_FLUSH        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_result", 32'(bus.o_RESULT), 32'd0);
        chk_eq("reset_full", 32'(bus.o_WINDOW_FULL), 32'd0);
        chk_eq("reset_valid", 32'(bus.o_RESULT_VALID), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 chk_eq("ready_after_reset", 32'(bus.o_SAMPLE_READY), 32'd1);

        run_op(12'd160, 2'b00, res, err, lat, full_upd, rdy_low);
        chk_eq("first_avg", 32'(res), 32'd10);
        chk_eq("first_avg_lat", 32'(lat), 32'd2);
        chk_eq("first_avg_err", 32'(err), 32'd0);

        // Reset asserted mid-operation, while the engine sits in UPDATE
        @(negedge clk);
        bus.i_SAMPLE = 12'd800; bus.i_MODE = 2'b00; bus.i_SAMPLE_VALID = 1'b1;
        @(posedge clk); #1;
        bus.i_SAMPLE_VALID = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_eq("midrst_result", 32'(bus.o_RESULT), 32'd0);
        chk_eq("midrst_valid", 32'(bus.o_RESULT_VALID), 32'd0);
        chk_eq("midrst_err", 32'(bus.o_ERR), 32'd0);
        p0 = pulses;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 chk_eq("midrst_ready", 32'(bus.o_SAMPLE_READY), 32'd1);
        chk_eq("midrst_no_pulse", 32'(pulses - p0), 32'd0);

        run_op(12'd160, 2'b00, res, err, lat, full_upd, rdy_low);
        chk_eq("post_reset_avg", 32'(res), 32'd10);

        // Flush with a simultaneous sample: the 4095 must not enter the window
        do_flush(1'b1);
        p0 = pulses;
        repeat (4) @(posedge clk);
        chk_eq("flush_valid_no_pulse", 32'(pulses - p0), 32'd0);
        #1 chk_eq("flush_clears_full", 32'(bus.o_WINDOW_FULL), 32'd0);

        for (int i = 1; i <= 16; i++) begin
            run_op(12'd100, 2'b00, res, err, lat, full_upd, rdy_low);
            if (i == 15) begin
                chk_eq("fill15_avg", 32'(res), 32'd93);
                chk_eq("fill15_full", 32'(full_upd), 32'd0);
            end
            if (i == 16) begin
                chk_eq("steady_avg", 32'(res), 32'd100);
                chk_eq("fill16_full_at_update", 32'(full_upd), 32'd1);
            end
        end
        run_op(12'd100, 2'b01, res, err, lat, full_upd, rdy_low);
        chk_eq("steady_var", 32'(res), 32'd0);
        chk_eq("steady_var_lat", 32'(lat), 32'd2);

        run_op(12'd1700, 2'b00, res, err, lat, full_upd, rdy_low);
        chk_eq("wrap_avg", 32'(res), 32'd200);

        do_flush(1'b0);
        for (int i = 0; i < 16; i++) begin
            run_op((i % 2 == 1) ? 12'd4000 : 12'd0, (i == 15) ? 2'b01 : 2'b00,
                   res, err, lat, full_upd, rdy_low);
        end
        chk_eq("alt_var", 32'(res), 32'd4000000);

        run_op(12'd0, 2'b10, res, err, lat, full_upd, rdy_low);
`ifdef MOVING_STATS_STDDEV_EN
        chk_eq("alt_sd", 32'(res), 32'd2000);
        chk_eq("alt_sd_lat", 32'(lat), 32'd14);
        chk_eq("alt_sd_ready_low", 32'(rdy_low), 32'd1);
        chk_eq("alt_sd_err", 32'(err), 32'd0);
`else
        chk_eq("sd_off_result", 32'(res), 32'd0);
        chk_eq("sd_off_err", 32'(err), 32'd1);
        chk_eq("sd_off_lat", 32'(lat), 32'd2);
`endif

        // Abort an operation in flight with flush
        @(negedge clk);
        bus.i_SAMPLE = 12'd4000; bus.i_SAMPLE_VALID = 1'b1;
`ifdef MOVING_STATS_STDDEV_EN
        bus.i_MODE = 2'b10;
`else
        bus.i_MODE = 2'b00;
`endif
        @(posedge clk); #1;
        bus.i_SAMPLE_VALID = 1'b0;
        p0 = pulses;
`ifdef MOVING_STATS_STDDEV_EN
        repeat (4) @(posedge clk);
`endif
        do_flush(1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk_eq("abort_no_pulse", 32'(pulses - p0), 32'd0);
        chk_eq("abort_full", 32'(bus.o_WINDOW_FULL), 32'd0);
        chk_eq("abort_result_kept", 32'(bus.o_RESULT), 32'(res));

        run_op(12'd160, 2'b00, res, err, lat, full_upd, rdy_low);
        chk_eq("after_abort_avg", 32'(res), 32'd10);

        run_op(12'd50, 2'b11, res, err, lat, full_upd, rdy_low);
        chk_eq("rsvd_result", 32'(res), 32'd0);
        chk_eq("rsvd_err", 32'(err), 32'd1);
        chk_eq("rsvd_lat", 32'(lat), 32'd2);
        chk_eq("rsvd_ready_with_valid", 32'(bus.o_SAMPLE_READY), 32'd1);

        run_op(12'd0, 2'b00, res, err, lat, full_upd, rdy_low);
        chk_eq("after_rsvd_avg", 32'(res), 32'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/moving_stats_engine.md
# moving_stats_engine

Parametrised moving-window statistics engine for the temperature-sensing datapath. It accepts one sample per valid/ready handshake into a circular window of 2^DEPTH_LOG2 entries. It maintains a running sum and a running sum of squares, and returns the window average, variance or standard deviation. It generalises the fixed 16-deep, 12-bit average/std-dev block: width and depth are parameters, variance is a new mode, and a flush control is added.

## Interface
- DATA_W, 12, sample width (unsigned).
- DEPTH_LOG2, 4, log2 of window depth N (N = 16 by default).
- i_CLK  in  1  clock, rising edge.
- i_RESET  in  1  asynchronous, active-high reset.
- i_SAMPLE_VALID  in  1  sample offered.
- o_SAMPLE_READY  out  1  engine can accept; high only in IDLE with i_FLUSH low.
- i_SAMPLE  in  DATA_W  unsigned sample.
- i_MODE  in  2  00 average, 01 variance, 10 std dev, 11 reserved; captured on acceptance.
- i_FLUSH  in  1  synchronous window clear.
- o_RESULT  out  2*DATA_W  result, zero-extended; held until next valid.
- o_RESULT_VALID  out  1  single-cycle pulse.
- o_ERR  out  1  pulses with o_RESULT_VALID for an unsupported mode.
- o_WINDOW_FULL  out  1  high once N samples have been accepted since reset/flush.

## Operation
- Reset values: o_RESULT 0, o_RESULT_VALID 0, o_ERR 0, o_WINDOW_FULL 0, o_SAMPLE_READY 1. Window, sums and fill count all 0. State IDLE.
- Acceptance: i_SAMPLE_VALID && o_SAMPLE_READY. The sample and mode are registered, and the oldest entry (at the write pointer) is read.
- Window behaviour:
  - Circular buffer with a DEPTH_LOG2-bit write pointer that wraps N-1 → 0.
  - Empty slots hold 0, so before the window is full the divisor is still N (zero-padded window).
- Running sums:
  - sum += new - oldest, width DATA_W+DEPTH_LOG2.
  - sumsq += new² - oldest², width 2*DATA_W+DEPTH_LOG2.
  - No overflow is possible at these widths.
- Arithmetic:
  - average = sum >> DEPTH_LOG2.
  - variance = (N*sumsq - sum²) >> 2*DEPTH_LOG2 (floor). The intermediate is 2*DATA_W+2*DEPTH_LOG2 bits and always ≥ 0.
  - std dev = floor(sqrt(variance)), DATA_W bits, computed by a restoring bit-serial root at 1 bit per cycle.
- FSM states: IDLE → UPDATE → VAR → (mode 10: ROOT × DATA_W cycles) → IDLE.
  - The valid pulse and result load occur on the transition into IDLE.
- o_WINDOW_FULL:
  - A fill counter saturates at N.
  - Asserts on the UPDATE edge of the Nth accepted sample.
- Flush:
  - Takes priority over a simultaneous sample; ready is low while i_FLUSH is high, so the sample is not accepted.
  - Clears window, sums, pointer, fill count and o_WINDOW_FULL on the next edge.
  - In any non-IDLE state, flush aborts the operation: no valid pulse, return to IDLE. o_RESULT keeps its old value.
- Reserved mode 11: result 0, o_ERR=1, normal average/variance latency. The window still updates.
- Reset mid-operation: immediate return to reset values; no pulse.

## Timing
- Sample accepted at edge k:
  - Sums are updated at k+1.
  - Variance is registered at k+2.
  - For average, variance and error modes, o_RESULT and the valid pulse appear at k+2.
  - For std dev, they appear at k+2+DATA_W (14 cycles at the defaults).
- o_SAMPLE_READY:
  - Returns high in the same cycle o_RESULT_VALID is high.
  - Back-to-back throughput: one sample per 3 cycles (average/variance), or per DATA_W+3 cycles (std dev).
- i_SAMPLE and i_MODE need only be stable in the acceptance cycle.

## Configuration
- MOVING_STATS_STDDEV_EN:
  - Defined: the square-root sub-module and ROOT state are compiled in, and mode 10 returns std dev.
  - Undefined: no root logic is built. Mode 10 behaves like mode 11 (result 0, o_ERR pulse, latency 2).

## Structure
- Shared package moving_stats_pkg holds:
  - mode enum: MODE_AVG, MODE_VAR, MODE_SD, MODE_RSVD.
  - FSM state enum.
  - width constants/functions for sum, sumsq and the variance intermediate, derived from DATA_W and DEPTH_LOG2.
- One sub-module, moving_stats_isqrt:
  - start/busy/done handshake.
  - 2*DATA_W-bit radicand in, DATA_W-bit root out.
  - Same clock and reset.

## Test plan
All scenarios use DATA_W=12 and DEPTH_LOG2=4.
- **Reset:** assert i_RESET mid-cycle → all outputs 0 immediately, ready=1 after release. A first sample of 160 in average mode → o_RESULT=10 two edges after acceptance.
- **Steady window:** 16 samples of 100, average mode → final result 100, o_WINDOW_FULL high from the 16th UPDATE edge. The same window in variance mode → 0.
- **Wrap-around:** after 16×100, accept 1700 in average mode → sum 3200, result 200, write pointer wraps to 1.
- **Variance and std dev:** 16 samples alternating 0/4000.
  - Variance mode → 4000000.
  - Std dev mode → 2000, valid exactly 14 edges after acceptance, ready low throughout.
- **Flush and errors:**
  - i_FLUSH during ROOT → no valid pulse, o_WINDOW_FULL=0. Next sample 160 in average mode → 10.
  - Flush and valid in the same cycle → sample not accepted.
  - Mode 11 → result 0 with an o_ERR pulse.
- **Macro off:** with MOVING_STATS_STDDEV_EN undefined, mode 10 → result 0 and o_ERR pulse at latency 2.
